// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - Stall vector bit indices (STALL_PC, STALL_IF)
//   - Bubble encoding for the IF output slot
//   - Fetch FSM state encoding
//   - PC step and sequential-PC helper
package if_fetch_unit_pkg;

    localparam int STALL_PC = 0;    // hold PC, issue no new request
    localparam int STALL_IF = 1;    // hold the IF output slot

    localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
    localparam logic [31:0] BUBBLE_PC    = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no request pending
        FETCH = 2'd1,   // request outstanding at pc
        HOLD  = 2'd2    // skid buffer full, no request issued
    } fetch_state_t;

    // Sequential PC; wraps naturally at 32 bits (FFFF_FFFC -> 0).
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched instruction that arrives while
// the IF output slot is stalled.
// Ports:
//   clk, reset          clock and synchronous active-low reset
//   load                capture {load_pc, load_instr} and mark valid
//   pop                 entry has been moved on; mark empty
//   flush               discard the entry (wins over load/pop)
//   load_pc/load_instr  data to capture
//   buf_valid/buf_pc/buf_instr  current contents
module fetch_skid_buf
    import if_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        buf_valid,
    output logic [31:0] buf_pc,
    output logic [31:0] buf_instr
);

    logic        valid_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            valid_reg <= 1'b0;
            pc_reg    <= BUBBLE_PC;
            instr_reg <= BUBBLE_INSTR;
        end else if (load) begin
            valid_reg <= 1'b1;
            pc_reg    <= load_pc;
            instr_reg <= load_instr;
        end else if (pop) begin
            valid_reg <= 1'b0;
            pc_reg    <= BUBBLE_PC;
            instr_reg <= BUBBLE_INSTR;
        end
    end

    assign buf_valid = valid_reg;
    assign buf_pc    = pc_reg;
    assign buf_instr = instr_reg;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one request
// outstanding to instruction memory, and presents {IF_PC, IF_Instruction,
// IF_valid} to the IF/ID register. A one-entry skid buffer catches a fetch
// that completes while the output slot is stalled.
// Ports:
//   clk, reset            clock and synchronous active-low reset
//   stall[5:0]            [0] hold PC / no new request, [1] hold IF output
//   redirect_valid/target taken branch/jump from ID (target bits [1:0] ignored)
//   imem_req/addr         fetch request, address stable until imem_ack
//   imem_ack/rdata        fetch completion (may coincide with imem_req)
//   IF_PC/Instruction     presented slot; bubble is 0/0
//   IF_valid              presented slot holds a real instruction
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC          = 32'h0000_0000,
    parameter logic        FLUSH_ON_REDIRECT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_Instruction,
    output logic        IF_valid
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  addr_reg, addr_next;
    logic         req_reg;
    logic         kill_reg, kill_next;

    logic         slot_valid_reg, slot_valid_next;
    logic [31:0]  slot_pc_reg, slot_pc_next;
    logic [31:0]  slot_instr_reg, slot_instr_next;

    logic         skid_valid;
    logic [31:0]  skid_pc;
    logic [31:0]  skid_instr;

    logic         consume;
    logic         flush_now;
    logic         acked;
    logic         accept;
    logic         to_slot;
    logic         to_skid;
    logic         skid_pop;
    logic         skid_full_next;

    // Upper stall bits belong to later stages; redirect targets are word aligned.
    logic unused_bits;
    assign unused_bits = ^{stall[5:2], redirect_target[1:0]};

    fetch_skid_buf u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (to_skid),
        .pop        (skid_pop),
        .flush      (flush_now),
        .load_pc    (pc_reg),
        .load_instr (imem_rdata),
        .buf_valid  (skid_valid),
        .buf_pc     (skid_pc),
        .buf_instr  (skid_instr)
    );

    always_comb begin
        consume   = !stall[STALL_IF];
        flush_now = redirect_valid && FLUSH_ON_REDIRECT;

        // Acks are only meaningful while a request is outstanding.
        acked  = (state_reg == FETCH) && imem_ack;
        // A killed fetch, or one completing alongside a redirect, is wrong-path.
        accept = acked && !kill_reg && !redirect_valid;

        to_slot  = accept && (!slot_valid_reg || consume);
        to_skid  = accept && !to_slot;
        skid_pop = skid_valid && consume && !flush_now;

        skid_full_next = to_skid || (skid_valid && !skid_pop && !flush_now);

        // Output slot: flush beats everything, then new data, then the
        // skid entry, and a consumed slot with nothing to refill becomes a bubble.
        slot_valid_next = slot_valid_reg;
        slot_pc_next    = slot_pc_reg;
        slot_instr_next = slot_instr_reg;
        if (flush_now) begin
            slot_valid_next = 1'b0;
            slot_pc_next    = BUBBLE_PC;
            slot_instr_next = BUBBLE_INSTR;
        end else if (to_slot) begin
            slot_valid_next = 1'b1;
            slot_pc_next    = pc_reg;
            slot_instr_next = imem_rdata;
        end else if (skid_pop) begin
            slot_valid_next = 1'b1;
            slot_pc_next    = skid_pc;
            slot_instr_next = skid_instr;
        end else if (consume) begin
            slot_valid_next = 1'b0;
            slot_pc_next    = BUBBLE_PC;
            slot_instr_next = BUBBLE_INSTR;
        end

        // After a killed ack pc already holds the redirect target.
        pc_next = pc_reg;
        if (redirect_valid) begin
            pc_next = {redirect_target[31:2], 2'b00};
        end else if (acked && !kill_reg) begin
            pc_next = seq_pc(pc_reg);
        end

        kill_next = kill_reg;
        if (state_reg == FETCH) begin
            if (imem_ack) begin
                kill_next = 1'b0;
            end else if (redirect_valid) begin
                kill_next = 1'b1;
            end
        end

        state_next = state_reg;
        case (state_reg)
            FETCH: begin
                if (!imem_ack) begin
                    state_next = FETCH;
                end else if (skid_full_next) begin
                    state_next = HOLD;
                end else begin
                    state_next = stall[STALL_PC] ? IDLE : FETCH;
                end
            end
            IDLE, HOLD: begin
                if (skid_full_next) begin
                    state_next = HOLD;
                end else begin
                    state_next = stall[STALL_PC] ? IDLE : FETCH;
                end
            end
            default: state_next = IDLE;
        endcase

        // The request address must not move while a request is outstanding,
        // even if pc has already been redirected.
        addr_next = pc_next;
        if ((state_reg == FETCH) && !imem_ack) begin
            addr_next = addr_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            addr_reg       <= RESET_PC;
            req_reg        <= 1'b0;
            kill_reg       <= 1'b0;
            slot_valid_reg <= 1'b0;
            slot_pc_reg    <= BUBBLE_PC;
            slot_instr_reg <= BUBBLE_INSTR;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            addr_reg       <= addr_next;
            req_reg        <= (state_next == FETCH);
            kill_reg       <= kill_next;
            slot_valid_reg <= slot_valid_next;
            slot_pc_reg    <= slot_pc_next;
            slot_instr_reg <= slot_instr_next;
        end
    end

    assign imem_req       = req_reg;
    assign imem_addr      = addr_reg;
    assign IF_PC          = slot_pc_reg;
    assign IF_Instruction = slot_instr_reg;
    assign IF_valid       = slot_valid_reg;

endmodule
